uart_tx_sched: RTL and testbench

Transmit scheduler for `UARTB_CORE`. It shares one UART transmitter between four requesters, with round-robin arbitration. Each requester may send either a single byte (normal mode) or a 32-bit burst (burst mode, 4 bytes LSB first). The block sequences every baud/mode register write and data write to the core, so mode changes and divider changes only happen while the transmitter is fully idle. It sits between the requesting logic and the core's `d`/`wrtx`/`wrbaud` inputs.

---
 rtl/uart_tx_sched.sv | 156 +++++++++++++++
 tb/tb_uart_tx_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin transmit scheduler in front of the UARTB_CORE TX port.
// Serialises mode/divider writes so they only reach the core while it is fully idle.
module uart_tx_sched #(
  parameter logic [8:0] DIVIDER = 9'd7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [3:0]   burst,
  input  logic [127:0] req_data,
  output logic [3:0]   ack,
  input  logic         cfg_wr,
  input  logic [8:0]   cfg_div,
  input  logic         uart_thre,
  input  logic         uart_tend,
  output logic [31:0]  uart_d,
  output logic         uart_wrtx,
  output logic         uart_wrbaud,
  output logic         cur_mode,
  output logic         busy
);

  localparam logic [2:0] S_INIT    = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_SETMODE = 3'd3;
  localparam logic [2:0] S_WRITE   = 3'd4;
  localparam logic [2:0] S_GUARD   = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [8:0]  div_q, div_d;
  logic        cfg_pend_q, cfg_pend_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [1:0]  win_q, win_d;
  logic        tgt_mode_q, tgt_mode_d;
  logic [3:0]  ack_q, ack_d;
  logic [31:0] uart_d_q, uart_d_d;
  logic        wrtx_q, wrtx_d;
  logic        wrbaud_q, wrbaud_d;
  logic        cur_mode_q, cur_mode_d;
  logic        busy_q, busy_d;

  logic        grant_vld;
  logic [1:0]  grant_idx;
  logic [31:0] grant_word;

  // Lowest offset from rr_ptr wins; scanning downwards lets the nearest one overwrite.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = rr_ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (req[rr_ptr_q + 2'(k)]) begin
        grant_vld = 1'b1;
        grant_idx = rr_ptr_q + 2'(k);
      end
    end
  end

  assign grant_word = req_data[{grant_idx, 5'b0} +: 32];

  always_comb begin
    state_d    = state_q;
    div_d      = cfg_wr ? cfg_div : div_q;
    cfg_pend_d = cfg_pend_q;
    rr_ptr_d   = rr_ptr_q;
    win_d      = win_q;
    tgt_mode_d = tgt_mode_q;
    ack_d      = 4'b0;
    uart_d_d   = uart_d_q;
    wrtx_d     = 1'b0;
    wrbaud_d   = 1'b0;
    cur_mode_d = cur_mode_q;

    case (state_q)
      S_INIT: begin
        tgt_mode_d = 1'b0;
        state_d    = S_SETMODE;
      end
      S_IDLE: begin
        if (cfg_pend_q) begin
          tgt_mode_d = cur_mode_q;
          state_d    = S_DRAIN;
        end else if (grant_vld) begin
          win_d = grant_idx;
          if (burst[grant_idx] != cur_mode_q) begin
            tgt_mode_d = burst[grant_idx];
            state_d    = S_DRAIN;
          end else if (uart_thre) begin
            state_d = S_WRITE;
          end
        end
      end
      S_DRAIN:   if (uart_tend) state_d = S_SETMODE;
      S_SETMODE: state_d = S_GUARD;
      S_WRITE:   state_d = S_GUARD;
      S_GUARD:   state_d = S_IDLE;
      default:   state_d = S_INIT;
    endcase

    // Strobes are registered, so they are launched on the edge that enters the state.
    if (state_d == S_SETMODE) begin
      wrbaud_d   = 1'b1;
      uart_d_d   = {tgt_mode_d, 22'b0, div_q};
      cur_mode_d = tgt_mode_d;
      cfg_pend_d = 1'b0;
    end
    if (state_d == S_WRITE) begin
      wrtx_d   = 1'b1;
      ack_d    = 4'b0001 << win_d;
      uart_d_d = burst[win_d] ? grant_word : {24'b0, grant_word[7:0]};
      rr_ptr_d = win_d + 2'd1;
    end
    // A new divider request landing on the SETMODE edge must not be lost.
    if (cfg_wr) cfg_pend_d = 1'b1;

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_INIT;
      div_q      <= DIVIDER;
      cfg_pend_q <= 1'b0;
      rr_ptr_q   <= 2'd0;
      win_q      <= 2'd0;
      tgt_mode_q <= 1'b0;
      ack_q      <= 4'b0;
      uart_d_q   <= 32'b0;
      wrtx_q     <= 1'b0;
      wrbaud_q   <= 1'b0;
      cur_mode_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      cfg_pend_q <= cfg_pend_d;
      rr_ptr_q   <= rr_ptr_d;
      win_q      <= win_d;
      tgt_mode_q <= tgt_mode_d;
      ack_q      <= ack_d;
      uart_d_q   <= uart_d_d;
      wrtx_q     <= wrtx_d;
      wrbaud_q   <= wrbaud_d;
      cur_mode_q <= cur_mode_d;
      busy_q     <= busy_d;
    end
  end

  assign ack         = ack_q;
  assign uart_d      = uart_d_q;
  assign uart_wrtx   = wrtx_q;
  assign uart_wrbaud = wrbaud_q;
  assign cur_mode    = cur_mode_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed scenarios plus randomized traffic, all checked
// against a transaction-level model (round-robin pointer, programmed mode and divider).
module tb_uart_tx_sched;

  localparam logic [8:0] DIV = 9'd7;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req, burst, ack;
  logic [127:0] req_data;
  logic         cfg_wr;
  logic [8:0]   cfg_div;
  logic         uart_thre, uart_tend;
  logic [31:0]  uart_d;
  logic         uart_wrtx, uart_wrbaud, cur_mode, busy;

  uart_tx_sched #(.DIVIDER(DIV)) dut (
    .clk(clk), .rst(rst), .req(req), .burst(burst), .req_data(req_data), .ack(ack),
    .cfg_wr(cfg_wr), .cfg_div(cfg_div), .uart_thre(uart_thre), .uart_tend(uart_tend),
    .uart_d(uart_d), .uart_wrtx(uart_wrtx), .uart_wrbaud(uart_wrbaud),
    .cur_mode(cur_mode), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int         m_rr;
  bit         m_mode;
  logic [8:0] m_div;
  bit         m_init;
  int         gap_tx, gap_baud;
  int         n_acks = 0;
  int         ack_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs seen by that edge are captured first, outputs checked on negedge.
  task automatic step();
    logic [3:0]   r, b;
    logic [127:0] dat;
    logic         thre_p, tend_p, rst_p, cfgw;
    logic [8:0]   cdiv;
    logic [31:0]  exp_d;
    int           w;
    bit           found;
    r = req; b = burst; dat = req_data; thre_p = uart_thre; tend_p = uart_tend;
    rst_p = rst; cfgw = cfg_wr; cdiv = cfg_div;
    @(negedge clk);
    if (rst_p) begin
      chk("rst_ack", ack, 0);
      chk("rst_d", uart_d, 0);
      chk("rst_wrtx", uart_wrtx, 0);
      chk("rst_wrbaud", uart_wrbaud, 0);
      chk("rst_cur_mode", cur_mode, 0);
      chk("rst_busy", busy, 1);
      m_rr = 0; m_mode = 0; m_div = DIV; m_init = 1; gap_tx = 100; gap_baud = 100;
    end else begin
      gap_tx++; gap_baud++;
      chk("strobe_excl", uart_wrtx & uart_wrbaud, 0);
      if (uart_wrbaud) begin
        if (!m_init) chk("wrbaud_tend", tend_p, 1);
        else chk("init_mode", uart_d[31], 0);
        chk("wrbaud_div", uart_d[30:0], {22'b0, m_div});
        chk("cur_mode_upd", cur_mode, uart_d[31]);
        chk("busy_baud", busy, 1);
        m_mode = uart_d[31]; m_init = 0; gap_baud = 0;
      end
      if (uart_wrtx) begin
        chk("wrtx_thre", thre_p, 1);
        chk("gap_tx", gap_tx >= 3, 1);
        chk("gap_baud", gap_baud >= 3, 1);
        found = 0; w = 0;
        for (int k = 0; k < 4; k++)
          if (!found && r[(m_rr + k) % 4]) begin found = 1; w = (m_rr + k) % 4; end
        chk("wrtx_has_req", found, 1);
        chk("ack_winner", ack, 4'b0001 << w);
        chk("mode_match", b[w], m_mode);
        exp_d = b[w] ? dat[32*w +: 32] : {24'b0, dat[32*w +: 8]};
        chk("wrtx_data", uart_d, exp_d);
        m_rr = (w + 1) % 4; gap_tx = 0; n_acks++;
      end else begin
        chk("ack_idle", ack, 0);
      end
      if (cfgw) m_div = cdiv;
    end
  endtask

  task automatic wait_baud(input int maxc, input string tag, output int cyc);
    cyc = 0;
    do begin step(); cyc++; end while (!uart_wrbaud && cyc < maxc);
    chk(tag, uart_wrbaud, 1);
  endtask

  task automatic wait_tx(input int maxc, input string tag);
    int cyc = 0;
    do begin step(); cyc++; end while (!uart_wrtx && cyc < maxc);
    chk(tag, uart_wrtx, 1);
  endtask

  task automatic serve(input logic [3:0] r, input int nexp);
    ack_log.delete();
    req = r;
    for (int c = 0; c < 80 && ack_log.size() < nexp; c++) begin
      step();
      if (uart_wrtx) begin
        for (int i = 0; i < 4; i++) if (ack[i]) ack_log.push_back(i);
        req = req & ~ack;
      end
    end
    while (ack_log.size() < 4) ack_log.push_back(-1);
  endtask

  initial begin
    int  cyc;
    bit  seen, ack_before;
    logic [31:0] bd;

    rst = 1; req = 0; burst = 0; req_data = 0; cfg_wr = 0; cfg_div = 0;
    uart_thre = 1; uart_tend = 1;
    m_rr = 0; m_mode = 0; m_div = DIV; m_init = 1; gap_tx = 100; gap_baud = 100;
    repeat (3) step();

    // reset release: single init mode write
    rst = 0;
    wait_baud(4, "init_baud", cyc);
    chk("init_baud_latency", cyc <= 2, 1);
    chk("init_baud_d", uart_d, 32'h0000_0007);
    chk("init_cur_mode", cur_mode, 0);
    chk("init_ack", ack, 0);
    step();
    chk("init_single_baud", uart_wrbaud, 0);
    step();
    chk("idle_busy", busy, 0);

    // same-mode byte grant
    req = 4'b0001; burst = 0; req_data[31:0] = 32'h5A5A_5A41;
    step();
    chk("byte_wrtx", uart_wrtx, 1);
    chk("byte_d", uart_d, 32'h0000_0041);
    chk("byte_ack", ack, 4'b0001);
    req = 0;
    repeat (2) step();

    // round-robin order
    req_data = {32'h0000_0044, 32'h0000_0043, 32'h0000_0042, 32'h0000_0041};
    serve(4'b0110, 2);
    chk("rr_first", ack_log[0], 1);
    chk("rr_second", ack_log[1], 2);
    serve(4'b0101, 2);
    chk("rr_wrap_first", ack_log[0], 0);
    chk("rr_wrap_second", ack_log[1], 2);
    repeat (2) step();

    // burst needs mode change; core busy for 20 cycles
    uart_tend = 0; req = 4'b1000; burst = 4'b1000; req_data[127:96] = 32'h4443_4241;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("no_baud_while_busy", uart_wrbaud, 0);
    end
    uart_tend = 1;
    wait_baud(5, "burst_baud", cyc);
    chk("burst_baud_d", uart_d, 32'h8000_0007);
    wait_tx(10, "burst_wrtx");
    chk("burst_d", uart_d, 32'h4443_4241);
    chk("burst_ack", ack, 4'b1000);
    chk("burst_cur_mode", cur_mode, 1);
    req = 0;
    repeat (3) step();

    // divider change outranks a pending request
    uart_thre = 0; req = 4'b0001; burst = 4'b0001; req_data[31:0] = 32'h1122_3344;
    repeat (3) step();
    cfg_wr = 1; cfg_div = 9'd3;
    step();
    cfg_wr = 0; uart_thre = 1;
    seen = 0; ack_before = 0; bd = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (uart_wrtx) ack_before = 1;
      if (uart_wrbaud) begin seen = 1; bd = uart_d; end
    end
    chk("cfg_baud_seen", seen, 1);
    chk("cfg_baud_d", bd, 32'h8000_0003);
    chk("cfg_before_ack", ack_before, 0);
    wait_tx(10, "cfg_then_wrtx");
    chk("cfg_then_ack", ack, 4'b0001);
    req = 0;
    repeat (3) step();

    // reset while draining
    uart_tend = 0; req = 4'b0010; burst = 4'b0000;
    repeat (4) step();
    chk("drain_no_baud", uart_wrbaud, 0);
    rst = 1;
    step();
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_mode", cur_mode, 0);
    rst = 0; req = 0; uart_tend = 1;
    wait_baud(4, "reinit_baud", cyc);
    chk("reinit_baud_d", uart_d, 32'h0000_0007);
    repeat (3) step();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      step();
      for (int i = 0; i < 4; i++) begin
        if (ack[i]) req[i] = 0;
        else if (!req[i] && $urandom_range(0, 7) == 0) begin
          req[i] = 1;
          burst[i] = 1'($urandom_range(0, 1));
          req_data[32*i +: 32] = $urandom;
        end
      end
      uart_thre = ($urandom_range(0, 4) != 0);
      uart_tend = ($urandom_range(0, 3) != 0);
      cfg_wr    = ($urandom_range(0, 63) == 0);
      cfg_div   = 9'($urandom);
    end
    cfg_wr = 0; req = 0;
    repeat (10) step();
    chk("random_progress", n_acks > 100, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
